// File: rtl/ins_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : ins_dispatch
// Purpose  : Instruction dispatcher placed in front of fpga_top. Host
//            instructions are buffered in a FIFO. Nothing issues until both
//            DDR4 controllers report calibration complete. SYNC barrier
//            instructions are consumed here and never forwarded. A SYNC
//            stalls issue until the core has been idle for IDLE_GUARD
//            consecutive cycles.
// Ports    : core_clk, sys_rst_n        - clock, synchronous active-low reset
//            c0/c1_init_calib_complete  - DDR calibration status
//            host_valid/host_ready/host_ins - host instruction push interface
//            ins_valid/ins_ready/ins    - AXI-stream style output to fpga_top
//            working                    - fpga_top busy indication
//            fifo_cnt, issued_cnt, sync_busy - status outputs
// Revision : 1.0 - initial release
// ============================================================================
module ins_dispatch #(
    parameter int          DEPTH      = 16,
    parameter int          ADDR_W     = $clog2(DEPTH),
    parameter int          IDLE_GUARD = 4,
    parameter logic [3:0]  SYNC_OP    = 4'hF
) (
    input  logic              core_clk,
    input  logic              sys_rst_n,
    input  logic              c0_init_calib_complete,
    input  logic              c1_init_calib_complete,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [63:0]       host_ins,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [63:0]       ins,
    input  logic              working,
    output logic [ADDR_W:0]   fifo_cnt,
    output logic [31:0]       issued_cnt,
    output logic              sync_busy
);

    localparam int              c_IDLE_W    = $clog2(IDLE_GUARD + 1);
    localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(IDLE_GUARD);

    typedef enum logic [1:0] {
        ST_WAIT_CALIB = 2'd0,
        ST_RUN        = 2'd1,
        ST_SYNC_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_IDLE_W-1:0]   r_idle;
    logic [c_IDLE_W-1:0]   w_idle_nxt;

    logic [63:0]           r_mem [DEPTH];
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_sync_pop;
    logic                  w_empty;
    logic                  w_out_free;
    logic [63:0]           w_head;
    logic                  w_head_sync;

    // ------------------------------------------------------------------
    // FIFO status and handshake qualifiers
    // ------------------------------------------------------------------
    assign host_ready  = (fifo_cnt < c_DEPTH_CNT);
    assign w_push      = host_valid && host_ready;
    assign w_empty     = (fifo_cnt == '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_sync = (w_head[63:60] == SYNC_OP);
    // The output register may take a new word when it is empty or its
    // current word leaves on this same edge.
    assign w_out_free  = !ins_valid || ins_ready;
    assign w_pop       = w_load || w_sync_pop;
    assign sync_busy   = (r_state == ST_SYNC_WAIT);

    // ------------------------------------------------------------------
    // FSM next-state, pop decisions and idle counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idle_nxt  = r_idle;
        w_load      = 1'b0;
        w_sync_pop  = 1'b0;
        case (r_state)
            ST_WAIT_CALIB: begin
                if (c0_init_calib_complete && c1_init_calib_complete) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!w_empty) begin
                    if (w_head_sync) begin
                        // The SYNC is dropped from the FIFO without touching
                        // the output register, so a pending word may still
                        // complete its handshake on this edge.
                        w_sync_pop  = 1'b1;
                        w_state_nxt = ST_SYNC_WAIT;
                        w_idle_nxt  = '0;
                    end else if (w_out_free) begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_SYNC_WAIT: begin
                if (r_idle == c_IDLE_MAX) begin
                    w_state_nxt = ST_RUN;
                end else if (!ins_valid && !working) begin
                    w_idle_nxt = r_idle + c_IDLE_W'(1);
                end else begin
                    w_idle_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_CALIB;
            end
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (!sys_rst_n) begin
            r_state <= ST_WAIT_CALIB;
            r_idle  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idle  <= w_idle_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (contents are not reset; pointers define validity)
    // ------------------------------------------------------------------
    always_ff @(posedge core_clk) begin
        if (sys_rst_n && w_push) begin
            r_mem[r_wr_ptr] <= host_ins;
        end
    end

    always_ff @(posedge core_clk) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (ADDR_W + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (ADDR_W + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register and issue counter
    // ------------------------------------------------------------------
    always_ff @(posedge core_clk) begin
        if (!sys_rst_n) begin
            ins_valid  <= 1'b0;
            ins        <= '0;
            issued_cnt <= '0;
        end else begin
            if (w_load) begin
                ins_valid <= 1'b1;
                ins       <= w_head;
            end else if (ins_ready) begin
                ins_valid <= 1'b0;
            end
            if (ins_valid && ins_ready) begin
                issued_cnt <= issued_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ins_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_dispatch
// Purpose  : Self-checking bench for ins_dispatch. A queue-based reference
//            model tracks expected outputs every cycle; directed scenarios
//            add literal expectations, followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_dispatch;

    localparam int DEPTH      = 16;
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int IDLE_GUARD = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              c0, c1;
    logic              host_valid;
    logic              host_ready;
    logic [63:0]       host_ins;
    logic              ins_valid;
    logic              ins_ready;
    logic [63:0]       ins;
    logic              working;
    logic [ADDR_W:0]   fifo_cnt;
    logic [31:0]       issued_cnt;
    logic              sync_busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    ins_dispatch #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .IDLE_GUARD (IDLE_GUARD),
        .SYNC_OP    (4'hF)
    ) dut (
        .core_clk               (clk),
        .sys_rst_n              (rst_n),
        .c0_init_calib_complete (c0),
        .c1_init_calib_complete (c1),
        .host_valid             (host_valid),
        .host_ready             (host_ready),
        .host_ins               (host_ins),
        .ins_valid              (ins_valid),
        .ins_ready              (ins_ready),
        .ins                    (ins),
        .working                (working),
        .fifo_cnt               (fifo_cnt),
        .issued_cnt             (issued_cnt),
        .sync_busy              (sync_busy)
    );

    // ------------------------------------------------------------------
    // Reference model: instruction queue, calibration flag, barrier flag
    // with its idle-run length, the output word and the issue count.
    // ------------------------------------------------------------------
    logic [63:0]  m_q[$];
    bit           m_cal     = 1'b0;
    bit           m_barrier = 1'b0;
    int           m_idle    = 0;
    bit           m_ov      = 1'b0;
    logic [63:0]  m_od      = '0;
    int unsigned  m_issued  = 0;

    always @(posedge clk) begin : model
        bit          push, hs, free, load, spop;
        logic [63:0] head;
        if (!rst_n) begin
            m_q.delete();
            m_cal     = 1'b0;
            m_barrier = 1'b0;
            m_idle    = 0;
            m_ov      = 1'b0;
            m_od      = '0;
            m_issued  = 0;
        end else begin
            push = host_valid && (m_q.size() < DEPTH);
            hs   = m_ov && ins_ready;
            free = !m_ov || ins_ready;
            load = 1'b0;
            spop = 1'b0;
            if (!m_cal) begin
                if (c0 && c1) m_cal = 1'b1;
            end else if (m_barrier) begin
                if (m_idle == IDLE_GUARD)    m_barrier = 1'b0;
                else if (!m_ov && !working)  m_idle = m_idle + 1;
                else                         m_idle = 0;
            end else if (m_q.size() > 0) begin
                head = m_q[0];
                if (head[63:60] == 4'hF) begin
                    spop      = 1'b1;
                    m_barrier = 1'b1;
                    m_idle    = 0;
                end else if (free) begin
                    load = 1'b1;
                end
            end
            if (hs) m_issued = m_issued + 1;
            if (load) begin
                m_od = m_q.pop_front();
                m_ov = 1'b1;
            end else if (ins_ready) begin
                m_ov = 1'b0;
            end
            if (spop) void'(m_q.pop_front());
            if (push) m_q.push_back(host_ins);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("host_ready", 64'(host_ready), 64'(m_q.size() < DEPTH));
            chk("fifo_cnt",   64'(fifo_cnt),   64'(m_q.size()));
            chk("ins_valid",  64'(ins_valid),  64'(m_ov));
            chk("ins",        ins,             m_od);
            chk("issued_cnt", 64'(issued_cnt), 64'(m_issued));
            chk("sync_busy",  64'(sync_busy),  64'(m_barrier));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push1(input logic [63:0] d);
        host_valid = 1'b1;
        host_ins   = d;
        tick();
        host_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; c0 = 1'b0; c1 = 1'b0;
        host_valid = 1'b0; host_ins = '0; ins_ready = 1'b0; working = 1'b0;
        repeat (3) tick();
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Reset state
        chk("rst_fifo_cnt",   64'(fifo_cnt),   64'd0);
        chk("rst_ins_valid",  64'(ins_valid),  64'd0);
        chk("rst_issued",     64'(issued_cnt), 64'd0);
        chk("rst_host_ready", 64'(host_ready), 64'd1);
        chk("rst_ins",        ins,             64'd0);

        // Calibration gate
        c0 = 1'b1; ins_ready = 1'b1;
        push1(64'hA1); push1(64'hA2); push1(64'hA3);
        chk("calib_fifo_cnt", 64'(fifo_cnt), 64'd3);
        tick();
        chk("calib_hold_valid", 64'(ins_valid), 64'd0);
        c1 = 1'b1;
        repeat (8) tick();
        chk("calib_issued", 64'(issued_cnt), 64'd3);

        // Streaming and latency
        host_valid = 1'b1; host_ins = 64'd1;
        tick();
        chk("lat_not_yet", 64'(ins_valid), 64'd0);
        host_ins = 64'd2;
        tick();
        chk("lat_valid", 64'(ins_valid), 64'd1);
        chk("lat_first", ins, 64'd1);
        for (int i = 3; i <= 32; i++) begin
            host_ins = 64'(i);
            tick();
        end
        host_valid = 1'b0;
        repeat (5) tick();
        chk("stream_issued", 64'(issued_cnt), 64'd35);

        // Backpressure and full
        ins_ready = 1'b0;
        for (int i = 0; i < 17; i++) push1(64'h100 + 64'(i));
        chk("full_cnt",   64'(fifo_cnt),   64'd16);
        chk("full_ready", 64'(host_ready), 64'd0);
        host_valid = 1'b1; host_ins = 64'h1FF;
        tick();
        host_valid = 1'b0;
        chk("full_reject_cnt", 64'(fifo_cnt), 64'd16);
        chk("full_stable_ins", ins, 64'h100);
        ins_ready = 1'b1;
        repeat (20) tick();
        chk("bp_issued", 64'(issued_cnt), 64'd52);
        chk("bp_drained", 64'(fifo_cnt), 64'd0);

        // SYNC barrier with idle-counter restart
        working = 1'b1;
        push1(64'hA); push1(64'hF000_0000_0000_0000); push1(64'hB);
        chk("sync_busy_on", 64'(sync_busy), 64'd1);
        chk("sync_issued_a", 64'(issued_cnt), 64'd53);
        repeat (10) tick();
        chk("sync_hold_busy", 64'(sync_busy), 64'd1);
        chk("sync_hold_cnt", 64'(fifo_cnt), 64'd1);
        working = 1'b0; tick(); tick();
        working = 1'b1; tick();
        working = 1'b0; tick(); tick(); tick();
        chk("sync_restart_busy", 64'(sync_busy), 64'd1);
        tick();
        chk("sync_guard_busy", 64'(sync_busy), 64'd1);
        tick();
        chk("sync_release", 64'(sync_busy), 64'd0);
        chk("sync_release_nv", 64'(ins_valid), 64'd0);
        tick();
        chk("sync_b_valid", 64'(ins_valid), 64'd1);
        chk("sync_b_data", ins, 64'hB);
        tick();
        chk("sync_issued", 64'(issued_cnt), 64'd54);

        // Mid-operation reset
        ins_ready = 1'b0;
        for (int i = 0; i < 6; i++) push1(64'h300 + 64'(i));
        chk("mid_cnt",   64'(fifo_cnt),  64'd5);
        chk("mid_valid", 64'(ins_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_cnt",    64'(fifo_cnt),   64'd0);
        chk("mid_rst_valid",  64'(ins_valid),  64'd0);
        chk("mid_rst_ins",    ins,             64'd0);
        chk("mid_rst_issued", 64'(issued_cnt), 64'd0);
        ins_ready = 1'b1;
        push1(64'h400); push1(64'h401);
        repeat (6) tick();
        chk("mid_reissue", 64'(issued_cnt), 64'd2);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            host_valid = ($urandom_range(0, 1) == 1);
            host_ins   = {($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14)),
                          60'({$urandom, $urandom})};
            ins_ready  = ($urandom_range(0, 9) < 7);
            working    = ($urandom_range(0, 9) < 3);
            c0         = ($urandom_range(0, 9) != 0);
            c1         = ($urandom_range(0, 9) != 0);
            rst_n      = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1'b1; host_valid = 1'b0; ins_ready = 1'b1; working = 1'b0;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
